reg_file_arbiter: RTL and testbench

//  Sits in front of the 32x8 register file (one shared X write/read address, one Y read address).

---
 rtl/reg_file_arbiter_if.sv | 43 ++++
 rtl/reg_file_arbiter.sv | 121 ++++++++++++
 tb/tb_reg_file_arbiter.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_arbiter_if.sv
// Bundle of CPU, debug, clear and register-file signals around the arbiter; no latency of its own.
// slave = arbiter side; master = requesters plus register file, which honour cpu_stall and dbg_req/dbg_ack.
interface reg_file_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic              cpu_en;
    logic [DATA_W-1:0] cpu_din;
    logic [ADDR_W-1:0] cpu_adrx;
    logic [ADDR_W-1:0] cpu_adry;
    logic              cpu_wr;
    logic              cpu_stall;
    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_adr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_ack;
    logic [DATA_W-1:0] dbg_rdata;
    logic              clr_start;
    logic              clr_busy;
    logic              clr_done;
    logic [DATA_W-1:0] rf_din;
    logic [ADDR_W-1:0] rf_adrx;
    logic [ADDR_W-1:0] rf_adry;
    logic              rf_wr;
    logic [DATA_W-1:0] rf_dx;

    modport slave (
        input  cpu_en, cpu_din, cpu_adrx, cpu_adry, cpu_wr,
        input  dbg_req, dbg_we, dbg_adr, dbg_wdata,
        input  clr_start, rf_dx,
        output cpu_stall, dbg_ack, dbg_rdata, clr_busy, clr_done,
        output rf_din, rf_adrx, rf_adry, rf_wr
    );

    modport master (
        output cpu_en, cpu_din, cpu_adrx, cpu_adry, cpu_wr,
        output dbg_req, dbg_we, dbg_adr, dbg_wdata,
        output clr_start, rf_dx,
        input  cpu_stall, dbg_ack, dbg_rdata, clr_busy, clr_done,
        input  rf_din, rf_adrx, rf_adry, rf_wr
    );
endinterface

// File: rtl/reg_file_arbiter.sv
// Shares the register file between CPU, debug host and clear sequencer (clear built only with REGARB_CLEAR_EN).
// Debug ack two cycles after req is sampled, clear takes 2**ADDR_W cycles; cpu_stall holds the CPU meanwhile.
module reg_file_arbiter #(
    parameter int                 DATA_W  = 8,
    parameter int                 ADDR_W  = 5,
    parameter logic [DATA_W-1:0]  CLR_VAL = '0
) (
    input  logic               clk,
    input  logic               rst,
    reg_file_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
`ifdef REGARB_CLEAR_EN
        CLEAR   = 2'd1,
`endif
        DBG_ACC = 2'd2,
        DBG_ACK = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              clr_done_q;
    logic [DATA_W-1:0] dbg_rdata_q;

`ifdef REGARB_CLEAR_EN
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_nxt;
    logic              clr_last;

    assign clr_last = (cnt == {ADDR_W{1'b1}});
`endif

    always_comb begin
        state_nxt     = state;
        bus.rf_din    = bus.cpu_din;
        bus.rf_adrx   = bus.cpu_adrx;
        bus.rf_adry   = bus.cpu_adry;
        bus.rf_wr     = 1'b0;
        bus.cpu_stall = 1'b1;
`ifdef REGARB_CLEAR_EN
        cnt_nxt       = cnt;
`endif
        case (state)
            IDLE: begin
                bus.rf_wr     = bus.cpu_wr;
                bus.cpu_stall = 1'b0;
                // Requests are only looked at while the CPU is halted; otherwise they stay pending.
`ifdef REGARB_CLEAR_EN
                if (!bus.cpu_en && bus.clr_start) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end else if (!bus.cpu_en && bus.dbg_req) begin
                    state_nxt = DBG_ACC;
                end
`else
                if (!bus.cpu_en && bus.dbg_req) begin
                    state_nxt = DBG_ACC;
                end
`endif
            end
`ifdef REGARB_CLEAR_EN
            CLEAR: begin
                bus.rf_adrx = cnt;
                bus.rf_din  = CLR_VAL;
                bus.rf_wr   = 1'b1;
                cnt_nxt     = cnt + 1'b1;
                if (clr_last) begin
                    state_nxt = IDLE;
                end
            end
`endif
            DBG_ACC: begin
                bus.rf_adrx = bus.dbg_adr;
                bus.rf_din  = bus.dbg_wdata;
                bus.rf_wr   = bus.dbg_we;
                state_nxt   = DBG_ACK;
            end
            DBG_ACK: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            clr_done_q  <= 1'b0;
            dbg_rdata_q <= '0;
`ifdef REGARB_CLEAR_EN
            cnt         <= '0;
`endif
        end else begin
            state <= state_nxt;
            // rf_dx still shows the pre-write contents here, so a debug write returns the old value.
            if (state == DBG_ACC) begin
                dbg_rdata_q <= bus.rf_dx;
            end
`ifdef REGARB_CLEAR_EN
            cnt        <= cnt_nxt;
            clr_done_q <= (state == CLEAR) && clr_last;
`else
            clr_done_q <= 1'b0;
`endif
        end
    end

    assign bus.dbg_ack   = (state == DBG_ACK);
    assign bus.dbg_rdata = dbg_rdata_q;
    assign bus.clr_done  = clr_done_q;
`ifdef REGARB_CLEAR_EN
    assign bus.clr_busy  = (state == CLEAR);
`else
    assign bus.clr_busy  = 1'b0;
`endif

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Randomized bench: a behavioural 32x8 register file plus a golden copy updated per transaction.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_reg_file_arbiter;

    localparam logic [7:0] CLR_VAL = 8'h00;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic seed_mem = 1'b1;

    logic [7:0] rf_mem   [32];
    logic [7:0] init_val [32];
    logic [7:0] golden   [32];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    reg_file_arbiter_if #(.DATA_W(8), .ADDR_W(5)) bus ();

    reg_file_arbiter #(.DATA_W(8), .ADDR_W(5), .CLR_VAL(CLR_VAL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Register file: asynchronous X read, write on the rising edge.
    always @(posedge clk) begin
        if (seed_mem) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= init_val[i];
        end else if (bus.rf_wr) begin
            rf_mem[bus.rf_adrx] <= bus.rf_din;
        end
    end
    assign bus.rf_dx = rf_mem[bus.rf_adrx];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic cpu_burst(input int n);
        logic [4:0] a;
        logic [7:0] d;
        logic       w;
        bus.cpu_en  = 1'b1;
        bus.dbg_req = 1'b0;
        for (int i = 0; i < n; i++) begin
            a = 5'($urandom);
            d = 8'($urandom);
            w = 1'($urandom_range(0, 1));
            bus.cpu_adrx  = a;
            bus.cpu_din   = d;
            bus.cpu_adry  = 5'($urandom);
            bus.cpu_wr    = w;
            bus.clr_start = 1'($urandom_range(0, 1));
            sample();
            check("cpu_rf_wr",   bus.rf_wr,     w);
            check("cpu_rf_adrx", bus.rf_adrx,   a);
            check("cpu_rf_din",  bus.rf_din,    d);
            check("cpu_rf_adry", bus.rf_adry,   bus.cpu_adry);
            check("cpu_stall",   bus.cpu_stall, 0);
            check("cpu_busy",    bus.clr_busy,  0);
            check("cpu_ack",     bus.dbg_ack,   0);
            tick();
            if (w) golden[a] = d;
        end
        bus.cpu_wr    = 1'b0;
        bus.clr_start = 1'b0;
    endtask

    // Debug access; hold > 0 keeps the CPU running that many cycles with the request pending.
    task automatic dbg_op(input logic we, input logic [4:0] adr, input logic [7:0] wd,
                          input int hold, input logic clr);
        int lat;
        logic [7:0] old;
        old           = golden[adr];
        bus.dbg_req   = 1'b1;
        bus.dbg_we    = we;
        bus.dbg_adr   = adr;
        bus.dbg_wdata = wd;
        bus.cpu_wr    = 1'b0;
        bus.clr_start = clr;
        bus.cpu_en    = (hold > 0);
        for (int i = 0; i < hold; i++) begin
            sample();
            check("hold_ack",   bus.dbg_ack,   0);
            check("hold_stall", bus.cpu_stall, 0);
            tick();
        end
        bus.cpu_en = 1'b0;
        sample();
        check("req_stall", bus.cpu_stall, 0);
        lat = 0;
        while (lat < 8) begin
            tick();
            lat++;
            if (lat == 1) begin
                bus.cpu_wr   = 1'b1;
                bus.cpu_adrx = 5'($urandom);
                bus.cpu_din  = 8'($urandom);
                bus.cpu_adry = 5'($urandom);
            end
            sample();
            if (lat == 1) begin
                check("acc_stall", bus.cpu_stall, 1);
                check("acc_wr",    bus.rf_wr,     we);
                check("acc_adrx",  bus.rf_adrx,   adr);
                check("acc_din",   bus.rf_din,    wd);
                check("acc_adry",  bus.rf_adry,   bus.cpu_adry);
            end
            if (bus.dbg_ack) break;
        end
        check("dbg_latency", lat, 2);
        check("dbg_rdata",   bus.dbg_rdata, old);
        check("ack_stall",   bus.cpu_stall, 1);
        check("ack_rf_wr",   bus.rf_wr,     0);
        if (we) golden[adr] = wd;
        tick();
        bus.dbg_req   = 1'b0;
        bus.cpu_wr    = 1'b0;
        bus.clr_start = 1'b0;
        sample();
        check("ack_pulse", bus.dbg_ack,   0);
        check("post_stall", bus.cpu_stall, 0);
        tick();
    endtask

`ifdef REGARB_CLEAR_EN
    task automatic do_clear(input bit with_dbg, input bit cpu_mid, input int rst_at);
        int lat;
        bus.cpu_en    = 1'b0;
        bus.cpu_wr    = 1'b0;
        bus.clr_start = 1'b1;
        if (with_dbg) begin
            bus.dbg_req = 1'b1;
            bus.dbg_we  = 1'b0;
            bus.dbg_adr = 5'd31;
        end
        tick();
        bus.clr_start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (cpu_mid && i == 10) begin
                bus.cpu_en   = 1'b1;
                bus.cpu_wr   = 1'b1;
                bus.cpu_adrx = 5'($urandom);
                bus.cpu_din  = 8'($urandom) | 8'h01;
            end
            if (i == rst_at) rst = 1'b1;
            sample();
            check("clr_busy",  bus.clr_busy,  1);
            check("clr_stall", bus.cpu_stall, 1);
            check("clr_rf_wr", bus.rf_wr,     1);
            check("clr_adrx",  bus.rf_adrx,   i);
            check("clr_din",   bus.rf_din,    CLR_VAL);
            check("clr_done_early", bus.clr_done, 0);
            check("clr_ack",   bus.dbg_ack,   0);
            tick();
            if (i == rst_at) begin
                rst = 1'b0;
                for (int j = 0; j <= i; j++) golden[j] = CLR_VAL;
                sample();
                check("rst_busy",  bus.clr_busy,  0);
                check("rst_stall", bus.cpu_stall, 0);
                check("rst_done",  bus.clr_done,  0);
                check("rst_rdata", bus.dbg_rdata, 0);
                tick();
                sample();
                check("rst_done2", bus.clr_done, 0);
                tick();
                return;
            end
        end
        for (int j = 0; j < 32; j++) golden[j] = CLR_VAL;
        bus.cpu_en = 1'b0;
        bus.cpu_wr = 1'b0;
        sample();
        check("clr_done",      bus.clr_done,  1);
        check("clr_busy_end",  bus.clr_busy,  0);
        check("clr_stall_end", bus.cpu_stall, 0);
        if (with_dbg) begin
            lat = 0;
            while (!bus.dbg_ack && lat < 8) begin
                tick();
                lat++;
                sample();
            end
            check("dbg_after_done", lat, 2);
            check("dbg_after_clr_rdata", bus.dbg_rdata, golden[31]);
            tick();
            bus.dbg_req = 1'b0;
        end else begin
            tick();
            sample();
            check("clr_done_pulse", bus.clr_done, 0);
        end
        tick();
    endtask
`endif

    initial begin
        int mism;
        int op;
        for (int i = 0; i < 32; i++) begin
            init_val[i] = 8'($urandom);
            golden[i]   = init_val[i];
        end
        bus.cpu_en = 1'b0; bus.cpu_din = '0; bus.cpu_adrx = '0; bus.cpu_adry = '0; bus.cpu_wr = 1'b0;
        bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_adr = '0; bus.dbg_wdata = '0;
        bus.clr_start = 1'b0;
        tick();
        seed_mem = 1'b0;
        tick();
        sample();
        check("rst_stall",  bus.cpu_stall, 0);
        check("rst_ack",    bus.dbg_ack,   0);
        check("rst_rdata0", bus.dbg_rdata, 0);
        check("rst_busy0",  bus.clr_busy,  0);
        check("rst_done0",  bus.clr_done,  0);
        check("rst_rf",     {bus.rf_wr, bus.rf_din, bus.rf_adrx, bus.rf_adry}, 0);
        tick();
        rst = 1'b0;

        bus.cpu_en = 1'b1; bus.cpu_wr = 1'b1; bus.cpu_adrx = 5'd3; bus.cpu_din = 8'hA5; bus.cpu_adry = 5'd9;
        sample();
        check("t1_rf_wr",   bus.rf_wr,   1);
        check("t1_rf_adrx", bus.rf_adrx, 3);
        check("t1_rf_din",  bus.rf_din,  8'hA5);
        check("t1_rf_adry", bus.rf_adry, 9);
        tick();
        golden[3] = 8'hA5;
        bus.cpu_wr = 1'b0;

        dbg_op(1'b1, 5'd7, 8'h3C, 0, 1'b0);
        dbg_op(1'b0, 5'd7, 8'h00, 0, 1'b0);
        dbg_op(1'b0, 5'd3, 8'h00, 5, 1'b0);

`ifdef REGARB_CLEAR_EN
        do_clear(1'b0, 1'b0, -1);
        dbg_op(1'b0, 5'd31, 8'h00, 0, 1'b0);
        for (int i = 0; i < 6; i++) dbg_op(1'b1, 5'($urandom), 8'($urandom), 0, 1'b0);
        do_clear(1'b1, 1'b0, -1);
        for (int i = 0; i < 32; i++) dbg_op(1'b1, 5'(i), 8'($urandom) | 8'h80, 0, 1'b0);
        do_clear(1'b0, 1'b1, -1);
        for (int i = 0; i < 32; i++) dbg_op(1'b1, 5'(i), 8'($urandom) | 8'h80, 0, 1'b0);
        do_clear(1'b0, 1'b0, 5);
        for (int i = 0; i < 8; i++) dbg_op(1'b0, 5'(i), 8'h00, 0, 1'b0);
`else
        bus.cpu_en    = 1'b0;
        bus.clr_start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample();
            check("noclr_busy",  bus.clr_busy,  0);
            check("noclr_done",  bus.clr_done,  0);
            check("noclr_stall", bus.cpu_stall, 0);
            check("noclr_wr",    bus.rf_wr,     0);
            tick();
        end
        bus.clr_start = 1'b0;
        dbg_op(1'b0, 5'd7, 8'h00, 0, 1'b1);
        dbg_op(1'b1, 5'd12, 8'h5A, 0, 1'b1);
`endif

        for (int k = 0; k < 80; k++) begin
            op = $urandom_range(0, 2);
            case (op)
                0: cpu_burst($urandom_range(1, 6));
                1: dbg_op(1'b1, 5'($urandom), 8'($urandom), $urandom_range(0, 3), 1'b0);
                default: dbg_op(1'b0, 5'($urandom), 8'h00, $urandom_range(0, 3), 1'b0);
            endcase
        end

        for (int i = 0; i < 32; i++) dbg_op(1'b0, 5'(i), 8'h00, 0, 1'b0);
        mism = 0;
        for (int i = 0; i < 32; i++) if (rf_mem[i] !== golden[i]) mism++;
        check("mem_mismatches", mism, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
